// File: rtl/branch_redirect.sv
// branch_redirect: resolves B/BEQZ/BNEZ/BTEQZ/JR in ID and hands a registered
// PC redirect to the fetch stage over a valid/ack handshake.
module branch_redirect #(
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [15:0] id_instr,
    input  logic [15:0] pc_plus1,
    input  logic [15:0] rx_val,
    input  logic [15:0] t_val,
    input  logic        opnd_ready,
    input  logic        pc_ack,
    output logic        redirect_valid,
    output logic [15:0] redirect_target,
    output logic        stall_id,
    output logic        flush_if,
    output logic [15:0] taken_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

    state_t      state, state_nx;
    logic [4:0]  op;
    logic        is_b, is_beqz, is_bnez, is_bteqz, is_jr, jump;
    logic        taken, accept, resolve;
    logic [15:0] off, target;

    assign op       = id_instr[15:11];
    assign is_b     = op == 5'b00010;
    assign is_beqz  = op == 5'b00100;
    assign is_bnez  = op == 5'b00101;
    assign is_bteqz = op == 5'b01100;
    assign is_jr    = op == 5'b11101 && id_instr[7:0] == 8'h00;
    assign jump     = is_b | is_beqz | is_bnez | is_bteqz | is_jr;
    assign taken    = is_b | is_jr | (is_beqz & rx_val == 16'h0) |
                      (is_bnez & rx_val != 16'h0) | (is_bteqz & t_val == 16'h0);
    assign off      = is_b ? {{5{id_instr[10]}}, id_instr[10:0]} : {{8{id_instr[7]}}, id_instr[7:0]};
    assign target   = is_jr ? rx_val : pc_plus1 + off;
    // A jump in ID is taken up unless a still-unacknowledged redirect occupies the output.
    assign accept   = id_valid & jump & (state != ISSUE | pc_ack);
    assign resolve  = accept & (is_b | opnd_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            redirect_target <= 16'h0;
            taken_cnt       <= 16'h0;
        end else begin
            state <= state_nx;
            if (resolve && taken) begin
                redirect_target <= target;
                taken_cnt       <= taken_cnt + 16'h1;
            end
        end
    end

    always_comb begin
        state_nx = resolve ? (taken ? ISSUE : IDLE) :
                   accept ? WAIT :
                   (state == ISSUE && !pc_ack) ? ISSUE : IDLE;
    end

    always_comb begin
        redirect_valid = state == ISSUE;
        stall_id       = id_valid & jump & ~resolve;
        flush_if       = !DELAY_SLOT && state == ISSUE && pc_ack;
    end
endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: directed per-cycle vector table plus a reset-mid-ISSUE sequence.
module tb_branch_redirect;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, opnd_ready, pc_ack;
    logic [15:0] id_instr, pc_plus1, rx_val, t_val;
    logic        rv0, stall0, flush0, rv1, stall1, flush1;
    logic [15:0] tgt0, cnt0, tgt1, cnt1;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    branch_redirect #(.DELAY_SLOT(1'b0)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .pc_plus1(pc_plus1),
        .rx_val(rx_val), .t_val(t_val), .opnd_ready(opnd_ready), .pc_ack(pc_ack),
        .redirect_valid(rv0), .redirect_target(tgt0), .stall_id(stall0), .flush_if(flush0),
        .taken_cnt(cnt0)
    );

    branch_redirect #(.DELAY_SLOT(1'b1)) dut_ds (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .pc_plus1(pc_plus1),
        .rx_val(rx_val), .t_val(t_val), .opnd_ready(opnd_ready), .pc_ack(pc_ack),
        .redirect_valid(rv1), .redirect_target(tgt1), .stall_id(stall1), .flush_if(flush1),
        .taken_cnt(cnt1)
    );

    typedef struct {
        logic        v;
        logic [15:0] instr, pc, rx, t;
        logic        rdy, ack;
        logic        e_rv;
        logic [15:0] e_tgt;
        logic        e_stall, e_flush;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        //            v  instr     pc        rx        t         rdy  ack   rv  tgt       stall flush cnt
        vecs[0]  = '{1, 16'h1005, 16'h0010, 16'h0000, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'd0};
        vecs[1]  = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0015, 0, 0, 16'd1};
        vecs[2]  = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0015, 0, 0, 16'd1};
        vecs[3]  = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0015, 0, 0, 16'd1};
        vecs[4]  = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0015, 0, 1, 16'd1};
        vecs[5]  = '{1, 16'h21FE, 16'h0020, 16'h0000, 16'h0000, 1, 0,   0, 16'h0015, 0, 0, 16'd1};
        vecs[6]  = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h001E, 0, 1, 16'd2};
        vecs[7]  = '{1, 16'h29FE, 16'h0020, 16'h0000, 16'h0000, 1, 0,   0, 16'h001E, 0, 0, 16'd2};
        vecs[8]  = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   0, 16'h001E, 0, 0, 16'd2};
        vecs[9]  = '{1, 16'hEA00, 16'h0030, 16'h0000, 16'h0000, 0, 0,   0, 16'h001E, 1, 0, 16'd2};
        vecs[10] = '{1, 16'hEA00, 16'h0030, 16'h0000, 16'h0000, 0, 0,   0, 16'h001E, 1, 0, 16'd2};
        vecs[11] = '{1, 16'hEA00, 16'h0030, 16'h4000, 16'h0000, 1, 0,   0, 16'h001E, 0, 0, 16'd2};
        vecs[12] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h4000, 0, 0, 16'd3};
        vecs[13] = '{1, 16'h1002, 16'h0100, 16'h0000, 16'h0000, 0, 0,   1, 16'h4000, 1, 0, 16'd3};
        vecs[14] = '{1, 16'h1002, 16'h0100, 16'h0000, 16'h0000, 0, 1,   1, 16'h4000, 0, 1, 16'd3};
        vecs[15] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0102, 0, 0, 16'd4};
        vecs[16] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0102, 0, 1, 16'd4};
        vecs[17] = '{1, 16'h6003, 16'hFFFE, 16'h1234, 16'h0000, 1, 0,   0, 16'h0102, 0, 0, 16'd4};
        vecs[18] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0001, 0, 0, 16'd5};
        vecs[19] = '{1, 16'h2105, 16'h0040, 16'h0005, 16'h0000, 1, 1,   1, 16'h0001, 0, 1, 16'd5};
        vecs[20] = '{1, 16'h4800, 16'h0041, 16'h0000, 16'h0000, 1, 0,   0, 16'h0001, 0, 0, 16'd5};
        vecs[21] = '{1, 16'h2100, 16'h0050, 16'h0000, 16'h0000, 0, 0,   0, 16'h0001, 1, 0, 16'd5};
        vecs[22] = '{0, 16'h2100, 16'h0050, 16'h0000, 16'h0000, 0, 0,   0, 16'h0001, 0, 0, 16'd5};
        vecs[23] = '{1, 16'h2100, 16'h0050, 16'h0000, 16'h0000, 1, 0,   0, 16'h0001, 0, 0, 16'd5};
        vecs[24] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0050, 0, 0, 16'd6};

        rst = 1'b0; id_valid = 0; id_instr = 0; pc_plus1 = 0; rx_val = 0; t_val = 0;
        opnd_ready = 0; pc_ack = 0;
        #12;
        chk("reset_rv", -1, 16'(rv0), 16'h0);
        chk("reset_tgt", -1, tgt0, 16'h0);
        chk("reset_stall", -1, 16'(stall0), 16'h0);
        chk("reset_flush", -1, 16'(flush0), 16'h0);
        chk("reset_cnt", -1, cnt0, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            id_valid = vecs[i].v; id_instr = vecs[i].instr; pc_plus1 = vecs[i].pc;
            rx_val = vecs[i].rx; t_val = vecs[i].t; opnd_ready = vecs[i].rdy; pc_ack = vecs[i].ack;
            #1;
            chk("redirect_valid", i, 16'(rv0), 16'(vecs[i].e_rv));
            chk("redirect_target", i, tgt0, vecs[i].e_tgt);
            chk("stall_id", i, 16'(stall0), 16'(vecs[i].e_stall));
            chk("flush_if", i, 16'(flush0), 16'(vecs[i].e_flush));
            chk("taken_cnt", i, cnt0, vecs[i].e_cnt);
            chk("flush_if_delay_slot", i, 16'(flush1), 16'h0);
            chk("redirect_valid_delay_slot", i, 16'(rv1), 16'(vecs[i].e_rv));
        end

        // Reset lands while a redirect is pending and an ack with a new B is presented.
        @(negedge clk);
        id_valid = 1; id_instr = 16'h1002; pc_plus1 = 16'h0100; opnd_ready = 1; pc_ack = 1;
        #1;
        chk("pre_reset_rv", 25, 16'(rv0), 16'h1);
        #1 rst = 1'b0;
        #1;
        chk("mid_reset_rv", 25, 16'(rv0), 16'h0);
        chk("mid_reset_tgt", 25, tgt0, 16'h0);
        chk("mid_reset_stall", 25, 16'(stall0), 16'h0);
        chk("mid_reset_flush", 25, 16'(flush0), 16'h0);
        chk("mid_reset_cnt", 25, cnt0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1; id_instr = 16'h2107; pc_plus1 = 16'h0200; rx_val = 16'h0007; opnd_ready = 1; pc_ack = 0;
        #1;
        chk("post_reset_stall", 26, 16'(stall0), 16'h0);
        @(negedge clk);
        id_valid = 0;
        #1;
        chk("post_reset_rv", 27, 16'(rv0), 16'h0);
        chk("post_reset_cnt", 27, cnt0, 16'h0);
        chk("post_reset_tgt", 27, tgt0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
